// File: rtl/mpsoc_oci_mem_sequencer_pkg.sv
// Shared types and constants for the OCI debug memory sequencer.
package mpsoc_oci_pkg;

   localparam int DEF_ADDR_W  = 10;
   localparam int DEF_TIMEOUT = 255;

   // Debug command payload layout
   localparam int JDO_W        = 38;
   localparam int JDO_RD_BIT   = 34;
   localparam int JDO_ADDR_LSB = 24;
   localparam int JDO_DATA_LSB = 3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2
   } seq_state_e;

endpackage

// File: rtl/mpsoc_oci_mem_sequencer_if.sv
// Word-addressed memory bus between the debug sequencer and the memory.
interface mpsoc_oci_mem_sequencer_if
   import mpsoc_oci_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W
);
   logic [ADDR_W-1:0] avm_address;
   logic              avm_read;
   logic              avm_write;
   logic [31:0]       avm_writedata;
   logic [31:0]       avm_readdata;
   logic              avm_waitrequest;

   modport master (
      output avm_address, avm_read, avm_write, avm_writedata,
      input  avm_readdata, avm_waitrequest
   );

   modport slave (
      input  avm_address, avm_read, avm_write, avm_writedata,
      output avm_readdata, avm_waitrequest
   );
endinterface

// File: rtl/mpsoc_oci_mem_sequencer_timeout.sv
// Counts stalled cycles of one memory access and flags the abort cycle.
module mpsoc_oci_timeout
   import mpsoc_oci_pkg::*;
#(
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);
   localparam int             CW   = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0]  LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] count;

   // expired fires on the TIMEOUT-th stalled cycle, so the access aborts at that edge
   assign expired = enable && (count == LAST);

   // stalled-cycle counter, held at zero while no access is in flight
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && !expired) begin
         count <= count + 1'b1;
      end
   end
endmodule

// File: rtl/mpsoc_oci_mem_sequencer.sv
// OCI debug memory sequencer: turns debug strobes into single memory reads/writes.
//
//  state    | meaning
//  ---------+-------------------------------------------------------
//  ST_IDLE  | waiting for a strobe; only state that accepts commands
//  ST_READ  | avm_read held until waitrequest drops or timeout
//  ST_WRITE | avm_write held until waitrequest drops or timeout
module mpsoc_oci_mem_sequencer
   import mpsoc_oci_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [JDO_W-1:0]   jdo,
   input  logic               take_action_ocimem_a,
   input  logic               take_action_ocimem_b,
   input  logic               take_no_action_ocimem_a,
   output logic [31:0]        MonDReg,
   output logic               monitor_ready,
   output logic               monitor_error,
   mpsoc_oci_mem_sequencer_if.master avm
);

   seq_state_e        state;
   logic [ADDR_W-1:0] addr;
   logic              any_strobe;
   logic              busy;
   logic              done;
   logic              wait_en;
   logic              wait_clr;
   logic              expired;
   logic              unused_jdo_bits;

   assign any_strobe = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
   assign busy       = (state != ST_IDLE);
   assign done       = busy && !avm.avm_waitrequest;
   assign wait_en    = busy && avm.avm_waitrequest;
   assign wait_clr   = !busy;

   assign avm.avm_address = addr;

   // payload bits outside the address and data fields carry nothing for this block
   assign unused_jdo_bits = ^{jdo[JDO_W-1:JDO_RD_BIT+1], jdo[JDO_DATA_LSB-1:0]};

   mpsoc_oci_timeout #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (wait_clr),
      .enable  (wait_en),
      .expired (expired)
   );

   // command acceptance, bus request handshake and monitor flags
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state             <= ST_IDLE;
         addr              <= '0;
         MonDReg           <= '0;
         avm.avm_writedata <= '0;
         avm.avm_read      <= 1'b0;
         avm.avm_write     <= 1'b0;
         monitor_ready     <= 1'b1;
         monitor_error     <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (take_action_ocimem_a) begin
                  monitor_error <= 1'b0;
                  addr          <= jdo[ADDR_W+JDO_ADDR_LSB-1:JDO_ADDR_LSB];
                  if (jdo[JDO_RD_BIT]) begin
                     state         <= ST_READ;
                     avm.avm_read  <= 1'b1;
                     monitor_ready <= 1'b0;
                  end
               end else if (take_action_ocimem_b) begin
                  monitor_error     <= 1'b0;
                  avm.avm_writedata <= jdo[JDO_RD_BIT:JDO_DATA_LSB];
                  MonDReg           <= jdo[JDO_RD_BIT:JDO_DATA_LSB];
                  state             <= ST_WRITE;
                  avm.avm_write     <= 1'b1;
                  monitor_ready     <= 1'b0;
               end else if (take_no_action_ocimem_a) begin
                  monitor_error <= 1'b0;
                  state         <= ST_READ;
                  avm.avm_read  <= 1'b1;
                  monitor_ready <= 1'b0;
               end
            end
            ST_READ, ST_WRITE: begin
               // strobes are never queued; a busy hit is reported instead
               if (any_strobe) begin
                  monitor_error <= 1'b1;
               end
               if (done) begin
                  if (state == ST_READ) begin
                     MonDReg <= avm.avm_readdata;
                  end
                  addr          <= addr + 1'b1;
                  avm.avm_read  <= 1'b0;
                  avm.avm_write <= 1'b0;
                  monitor_ready <= 1'b1;
                  state         <= ST_IDLE;
               end else if (expired) begin
                  avm.avm_read  <= 1'b0;
                  avm.avm_write <= 1'b0;
                  monitor_error <= 1'b1;
                  monitor_ready <= 1'b1;
                  state         <= ST_IDLE;
               end
            end
            default: begin
               state         <= ST_IDLE;
               avm.avm_read  <= 1'b0;
               avm.avm_write <= 1'b0;
               monitor_ready <= 1'b1;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_mpsoc_oci_mem_sequencer.sv
// Self-checking bench for the OCI debug memory sequencer.
module tb_mpsoc_oci_mem_sequencer;
   localparam int AW   = 10;
   localparam int TOUT = 255;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [37:0] jdo;
   logic        sa, sb, sn;
   logic [31:0] MonDReg;
   logic        monitor_ready;
   logic        monitor_error;

   int n_checks = 0;
   int n_fail   = 0;
   int rd_cycles = 0;
   int wr_cycles = 0;

   // behavioural model of what the outputs must be
   bit          m_busy  = 0;
   bit          m_is_rd = 0;
   int          m_waits = 0;
   int          m_addr  = 0;
   logic [31:0] m_mon   = '0;
   logic [31:0] m_wd    = '0;
   bit          m_err   = 0;

   mpsoc_oci_mem_sequencer_if #(.ADDR_W(AW)) bus ();

   mpsoc_oci_mem_sequencer #(.ADDR_W(AW), .TIMEOUT(TOUT)) dut (
      .clk                     (clk),
      .reset_n                 (reset_n),
      .jdo                     (jdo),
      .take_action_ocimem_a    (sa),
      .take_action_ocimem_b    (sb),
      .take_no_action_ocimem_a (sn),
      .MonDReg                 (MonDReg),
      .monitor_ready           (monitor_ready),
      .monitor_error           (monitor_error),
      .avm                     (bus.master)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [37:0] jdo_addr(input int a, input bit rd);
      logic [37:0] v;
      v = '0;
      v[33:24] = a[9:0];
      v[34] = rd;
      return v;
   endfunction

   function automatic logic [37:0] jdo_data(input logic [31:0] d);
      logic [37:0] v;
      v = '0;
      v[34:3] = d;
      return v;
   endfunction

   task automatic model_reset();
      m_busy = 0; m_is_rd = 0; m_waits = 0; m_addr = 0;
      m_mon = '0; m_wd = '0; m_err = 0;
   endtask

   task automatic model_start(input bit is_rd);
      m_busy = 1; m_is_rd = is_rd; m_waits = 0;
   endtask

   // one clock edge of the command-level model
   task automatic model_step();
      if (!m_busy) begin
         if (sa) begin
            m_err  = 0;
            m_addr = int'(jdo[33:24]);
            if (jdo[34]) model_start(1);
         end else if (sb) begin
            m_err = 0;
            m_wd  = jdo[34:3];
            m_mon = jdo[34:3];
            model_start(0);
         end else if (sn) begin
            m_err = 0;
            model_start(1);
         end
      end else begin
         if (sa || sb || sn) m_err = 1;
         if (!bus.avm_waitrequest) begin
            if (m_is_rd) m_mon = bus.avm_readdata;
            m_addr = (m_addr + 1) % (1 << AW);
            m_busy = 0;
         end else begin
            m_waits++;
            if (m_waits == TOUT) begin
               m_err  = 1;
               m_busy = 0;
            end
         end
      end
   endtask

   initial begin
      forever begin
         @(posedge clk or negedge reset_n);
         if (!reset_n) model_reset();
         else model_step();
      end
   end

   // per-cycle comparison of every output against the model
   initial begin
      forever begin
         @(negedge clk);
         check("avm_read",      {31'b0, bus.avm_read},  {31'b0, m_busy && m_is_rd});
         check("avm_write",     {31'b0, bus.avm_write}, {31'b0, m_busy && !m_is_rd});
         check("avm_address",   32'(bus.avm_address),   32'(m_addr));
         check("avm_writedata", bus.avm_writedata,      m_wd);
         check("MonDReg",       MonDReg,                m_mon);
         check("monitor_ready", {31'b0, monitor_ready}, {31'b0, !m_busy});
         check("monitor_error", {31'b0, monitor_error}, {31'b0, m_err});
         check("rd_wr_exclusive", {31'b0, bus.avm_read & bus.avm_write}, 32'd0);
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (bus.avm_read)  rd_cycles++;
         if (bus.avm_write) wr_cycles++;
      end
   end

   task automatic do_strobe(input bit a, input bit b, input bit n, input logic [37:0] d);
      @(negedge clk);
      sa = a; sb = b; sn = n; jdo = d;
      @(negedge clk);
      sa = 0; sb = 0; sn = 0; jdo = '0;
   endtask

   task automatic wait_idle(input int max, input string name);
      int n;
      n = 0;
      while (!monitor_ready && n < max) begin
         @(negedge clk);
         n++;
      end
      check(name, {31'b0, monitor_ready}, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b0;
      jdo = '0; sa = 0; sb = 0; sn = 0;
      bus.avm_waitrequest = 1'b0;
      bus.avm_readdata    = '0;
      repeat (2) @(negedge clk);
      check("reset_ready", {31'b0, monitor_ready}, 32'd1);
      check("reset_mon",   MonDReg, 32'd0);
      check("reset_addr",  32'(bus.avm_address), 32'd0);
      reset_n = 1'b1;
      @(negedge clk);

      // address load with read, zero wait
      bus.avm_readdata = 32'hDEADBEEF;
      rd_cycles = 0;
      do_strobe(1, 0, 0, jdo_addr(10'h005, 1));
      check("t1_ready_low", {31'b0, monitor_ready}, 32'd0);
      check("t1_read_addr", 32'(bus.avm_address), 32'h005);
      @(negedge clk);
      check("t1_ready_2cyc", {31'b0, monitor_ready}, 32'd1);
      check("t1_mon",        MonDReg, 32'hDEADBEEF);
      check("t1_addr_next",  32'(bus.avm_address), 32'h006);
      check("t1_rd_cycles",  32'(rd_cycles), 32'd1);

      // write with three stall cycles
      bus.avm_waitrequest = 1'b1;
      wr_cycles = 0;
      do_strobe(0, 1, 0, jdo_data(32'h12345678));
      repeat (3) @(negedge clk);
      bus.avm_waitrequest = 1'b0;
      wait_idle(20, "t2_idle");
      check("t2_wr_cycles", 32'(wr_cycles), 32'd4);
      check("t2_wdata",     bus.avm_writedata, 32'h12345678);
      check("t2_addr",      32'(bus.avm_address), 32'h007);

      // read-next at the top address wraps to zero
      do_strobe(1, 0, 0, jdo_addr(10'h3FF, 0));
      check("t3_load", 32'(bus.avm_address), 32'h3FF);
      bus.avm_readdata = 32'hCAFEF00D;
      do_strobe(0, 0, 1, '0);
      wait_idle(20, "t3_idle");
      check("t3_wrap", 32'(bus.avm_address), 32'h000);
      check("t3_mon",  MonDReg, 32'hCAFEF00D);

      // stuck waitrequest aborts after TIMEOUT stall cycles
      bus.avm_waitrequest = 1'b1;
      bus.avm_readdata    = 32'h55555555;
      rd_cycles = 0;
      do_strobe(0, 0, 1, '0);
      wait_idle(400, "t4_idle");
      bus.avm_waitrequest = 1'b0;
      check("t4_rd_cycles", 32'(rd_cycles), 32'd255);
      check("t4_error",     {31'b0, monitor_error}, 32'd1);
      check("t4_mon_keep",  MonDReg, 32'hCAFEF00D);
      check("t4_addr_keep", 32'(bus.avm_address), 32'h000);
      do_strobe(1, 0, 0, jdo_addr(10'h010, 0));
      check("t4_err_clear", {31'b0, monitor_error}, 32'd0);

      // simultaneous a and b: only the address load happens
      wr_cycles = 0;
      do_strobe(1, 1, 0, jdo_addr(10'h020, 0));
      @(negedge clk);
      check("t5_addr",      32'(bus.avm_address), 32'h020);
      check("t5_no_write",  32'(wr_cycles), 32'd0);
      check("t5_mon_keep",  MonDReg, 32'hCAFEF00D);
      // strobe while a read is stalled
      bus.avm_waitrequest = 1'b1;
      bus.avm_readdata    = 32'h0BADF00D;
      do_strobe(0, 0, 1, '0);
      do_strobe(0, 1, 0, jdo_data(32'h77777777));
      check("t5_busy_err", {31'b0, monitor_error}, 32'd1);
      bus.avm_waitrequest = 1'b0;
      wait_idle(20, "t5_idle");
      check("t5_err_sticky", {31'b0, monitor_error}, 32'd1);
      check("t5_mon",        MonDReg, 32'h0BADF00D);
      check("t5_addr_next",  32'(bus.avm_address), 32'h021);

      // reset asserted in the middle of a write
      bus.avm_waitrequest = 1'b1;
      do_strobe(0, 1, 0, jdo_data(32'hA5A5A5A5));
      @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      check("t6_write_drop", {31'b0, bus.avm_write}, 32'd0);
      check("t6_ready",      {31'b0, monitor_ready}, 32'd1);
      check("t6_mon",        MonDReg, 32'd0);
      check("t6_wdata",      bus.avm_writedata, 32'd0);
      check("t6_addr",       32'(bus.avm_address), 32'd0);
      check("t6_err",        {31'b0, monitor_error}, 32'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      bus.avm_waitrequest = 1'b0;
      bus.avm_readdata    = 32'h11112222;
      do_strobe(0, 0, 1, '0);
      wait_idle(20, "t6_idle");
      check("t6_post_mon",  MonDReg, 32'h11112222);
      check("t6_post_addr", 32'(bus.avm_address), 32'h001);

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/mpsoc_oci_mem_sequencer.md
MPSOC_OCI_MEM_SEQUENCER -- requirements
Module: mpsoc_oci_mem_sequencer

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  ADDR_W, 10, word-address width of debug memory port.
  TIMEOUT, 255, max cycles a memory access may wait before abort.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk  in  1  single clock for all logic.
  reset_n  in  1  asynchronous, active-low reset.
  jdo  in  38  debug command payload, valid in the strobe cycle.
  take_action_ocimem_a  in  1  address-load strobe; jdo[34]=1 also starts a read.
  take_action_ocimem_b  in  1  write strobe; data = jdo[34:3].
  take_no_action_ocimem_a  in  1  read-next strobe.
  MonDReg  out  32  last read data, or last write data.
  monitor_ready  out  1  high when idle and last command complete.
  monitor_error  out  1  sticky error flag.
  avm_address  out  ADDR_W  memory word address.
  avm_read  out  1  read request.
  avm_write  out  1  write request.
  avm_writedata  out  32  write data.
  avm_readdata  in  32  read data, valid when avm_read high and avm_waitrequest low.
  avm_waitrequest  in  1  memory stall.

Function
REQ-003 FSM SHALL have states IDLE, READ, WRITE; commands SHALL be accepted only in IDLE.
REQ-004 In IDLE, take_action_ocimem_a SHALL load addr <= jdo[ADDR_W+23:24]; if jdo[34]=1, the FSM SHALL enter READ at the new address.
REQ-005 In IDLE, take_action_ocimem_b SHALL capture jdo[34:3] into avm_writedata and MonDReg, and the FSM SHALL enter WRITE.
REQ-006 In IDLE, take_no_action_ocimem_a SHALL enter READ at the current addr.
REQ-007 Simultaneous strobes SHALL resolve with priority ocimem_a > ocimem_b > no_action_ocimem_a; losing strobes SHALL be discarded without error.
REQ-008 avm_read/avm_write SHALL assert the cycle after acceptance and hold, with address and data stable, until the cycle avm_waitrequest is low.
REQ-009 On read completion, MonDReg SHALL load avm_readdata in that same cycle; addr SHALL increment by 1 (mod 2^ADDR_W, so 2^ADDR_W-1 wraps to 0); the FSM SHALL return to IDLE.
REQ-010 On write completion, addr SHALL increment by 1 with the same wrap rule, and the FSM SHALL return to IDLE.
REQ-011 monitor_ready SHALL go low the cycle after acceptance and high the cycle after completion or abort; minimum command latency SHALL be 2 cycles (strobe to monitor_ready high with zero wait).
REQ-012 The wait counter SHALL clear on entering READ/WRITE and count each cycle with avm_waitrequest high; reaching TIMEOUT SHALL deassert the request, set monitor_error, leave MonDReg and addr unchanged, and return to IDLE.
REQ-013 Any strobe arriving while not in IDLE SHALL be dropped and SHALL set monitor_error.
REQ-014 monitor_error SHALL clear when the next command is accepted in IDLE.
REQ-015 avm_read and avm_write SHALL never be high together.

Reset
REQ-016 reset_n low SHALL force IDLE immediately; addr=0, MonDReg=0, avm_writedata=0, avm_read=0, avm_write=0, monitor_ready=1, monitor_error=0, wait counter=0.
REQ-017 Reset asserted mid-access SHALL abort the access with no MonDReg update; the first post-reset command SHALL behave as from power-up.

Structure
REQ-018 Package mpsoc_oci_pkg SHALL hold the state enum, jdo field bit positions (34, 24, 3), and default ADDR_W/TIMEOUT constants.
REQ-019 The wait counter SHALL be sub-module mpsoc_oci_timeout (clear, enable, expired output, TIMEOUT parameter); all other logic SHALL be flat.

Verification
REQ-020 Bench SHALL cover:
  Address load 0x005 with jdo[34]=1, waitrequest 0 -> avm_read one cycle at 0x005, MonDReg=readdata 0xDEADBEEF, addr=0x006, monitor_ready high 2 cycles after strobe.
  ocimem_b with data 0x12345678, waitrequest high 3 cycles -> avm_write held 4 cycles with stable data, then addr+1 and monitor_ready=1.
  Read-next at addr 0x3FF -> read at 0x3FF, addr wraps to 0x000.
  Waitrequest stuck high -> abort after 255 wait cycles, monitor_error=1, MonDReg unchanged; next accepted strobe clears error.
  ocimem_a and ocimem_b in the same cycle -> only the address load is executed; a strobe during READ sets monitor_error.
  reset_n pulsed low mid-WRITE -> avm_write drops asynchronously, all REQ-016 values restored.
